aes_multiblock_fsm: RTL and testbench

- Parametrised successor to the single-block AES HWPE control FSM.
- Sequences N consecutive 128-bit blocks per job, in encrypt or decrypt mode.
- Waits for the source and sink streamers to report ready before issuing requests.
- Counts completed blocks from the engine, supervises progress with a watchdog, and reports done/error to the slave.
- Sits between hwpe_ctrl slave/regfile, the streamer and the AES engine.

---
 rtl/aes_multiblock_fsm.sv | 182 ++++++++++++++++++
 tb/tb_aes_multiblock_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_multiblock_fsm.sv
// Multi-block AES job sequencer: waits for streamers, launches N blocks, counts engine
// completions, supervises progress with a watchdog and reports done/error to the slave.
module aes_multiblock_fsm #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned NB_W        = 16,
  parameter int unsigned WDOG_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start_i,
  input  logic [NB_W-1:0]   n_blocks_i,
  input  logic              mode_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic              src_ready_i,
  input  logic              snk_ready_i,
  input  logic              src_done_i,
  input  logic              snk_done_i,
  input  logic              fifo_empty_i,
  input  logic              blk_done_i,
  output logic              src_req_o,
  output logic              snk_req_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] snk_addr_o,
  output logic [NB_W+1:0]   trans_size_o,
  output logic [NB_W+1:0]   line_length_o,
  output logic              eng_clear_o,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  output logic              eng_mode_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [NB_W-1:0]   blk_cnt_o
);

  localparam int unsigned WordShift = $clog2(BLOCK_WORDS);

  typedef enum logic [2:0] {
    StIdle, StWaitReady, StStarting, StWorking, StFinished, StError
  } state_e;

  state_e              state_q, state_d;
  logic [NB_W-1:0]     n_q, n_d, blk_cnt_q, blk_cnt_d;
  logic                mode_q, mode_d, err_q, err_d;
  logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
  logic                src_seen_q, src_seen_d, snk_seen_q, snk_seen_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic                wd_active, wd_event;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      n_q        <= '0;
      blk_cnt_q  <= '0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      src_seen_q <= 1'b0;
      snk_seen_q <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      blk_cnt_q  <= blk_cnt_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      src_seen_q <= src_seen_d;
      snk_seen_q <= snk_seen_d;
      wdog_q     <= wdog_d;
    end
  end

  assign wd_active = (state_q == StWaitReady) || (state_q == StWorking);
  assign wd_event  = blk_done_i | src_done_i | snk_done_i;
  assign wdog_inc  = wdog_q + WDOG_W'(1);

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    blk_cnt_d    = blk_cnt_q;
    mode_d       = mode_q;
    err_d        = err_q;
    src_d        = src_q;
    dst_d        = dst_q;
    src_seen_d   = src_seen_q;
    snk_seen_d   = snk_seen_q;
    wdog_d       = '0;
    src_req_o    = 1'b0;
    snk_req_o    = 1'b0;
    eng_start_o  = 1'b0;
    eng_clear_o  = 1'b0;
    eng_enable_o = 1'b1;
    done_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        eng_clear_o = 1'b1;
        if (start_i) begin
          n_d       = n_blocks_i;
          mode_d    = mode_i;
          src_d     = src_base_i;
          dst_d     = dst_base_i;
          blk_cnt_d = '0;
          err_d     = 1'b0;
          state_d   = (n_blocks_i == '0) ? StFinished : StWaitReady;
        end
      end
      StWaitReady: begin
        if (src_ready_i && snk_ready_i) state_d = StStarting;
      end
      StStarting: begin
        src_req_o   = 1'b1;
        snk_req_o   = 1'b1;
        eng_start_o = 1'b1;
        src_seen_d  = 1'b0;
        snk_seen_d  = 1'b0;
        state_d     = StWorking;
      end
      StWorking: begin
        // Saturate at the job length so stray engine pulses cannot overshoot.
        if (blk_done_i && (blk_cnt_q != n_q)) blk_cnt_d = blk_cnt_q + NB_W'(1);
        if (src_done_i) src_seen_d = 1'b1;
        if (snk_done_i) snk_seen_d = 1'b1;
        if ((blk_cnt_d == n_q) && src_seen_d && snk_seen_d && fifo_empty_i) begin
          state_d = StFinished;
        end
      end
      StFinished: begin
        done_o       = 1'b1;
        eng_enable_o = 1'b0;
        state_d      = StIdle;
      end
      StError: begin
        done_o       = 1'b1;
        eng_enable_o = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Timeout wins over any transition decided above.
    if (wd_active) begin
      if (wd_event) begin
        wdog_d = '0;
      end else if (&wdog_inc) begin
        state_d = StError;
        err_d   = 1'b1;
      end else if (state_d == state_q) begin
        wdog_d = wdog_inc;
      end
    end

    if (clear) begin
      state_d    = StIdle;
      n_d        = '0;
      blk_cnt_d  = '0;
      mode_d     = 1'b0;
      err_d      = 1'b0;
      src_d      = '0;
      dst_d      = '0;
      src_seen_d = 1'b0;
      snk_seen_d = 1'b0;
      wdog_d     = '0;
    end
  end

  assign src_addr_o    = src_q;
  assign snk_addr_o    = dst_q;
  assign trans_size_o  = (NB_W + 2)'(n_q) << WordShift;
  assign line_length_o = trans_size_o;
  assign eng_mode_o    = mode_q;
  assign busy_o        = (state_q != StIdle);
  assign err_o         = err_q;
  assign blk_cnt_o     = blk_cnt_q;

endmodule

// File: tb/tb_aes_multiblock_fsm.sv
// Directed bench for aes_multiblock_fsm: a default instance plus a WDOG_W=4 instance
// sharing stimulus so the watchdog timeout is reachable quickly.
module tb_aes_multiblock_fsm;

  logic        clk = 1'b0;
  logic        reset_n, clear, start_i, mode_i;
  logic [15:0] n_blocks_i;
  logic [31:0] src_base_i, dst_base_i;
  logic        src_ready_i, snk_ready_i, src_done_i, snk_done_i, fifo_empty_i, blk_done_i;

  logic        a_src_req, a_snk_req, a_eng_clear, a_eng_start, a_eng_enable, a_eng_mode;
  logic        a_busy, a_done, a_err;
  logic [31:0] a_src_addr, a_snk_addr;
  logic [17:0] a_trans_size, a_line_length;
  logic [15:0] a_blk_cnt;

  logic        b_src_req, b_snk_req, b_eng_clear, b_eng_start, b_eng_enable, b_eng_mode;
  logic        b_busy, b_done, b_err;
  logic [31:0] b_src_addr, b_snk_addr;
  logic [17:0] b_trans_size, b_line_length;
  logic [15:0] b_blk_cnt;

  int checks = 0;
  int errors = 0;
  int req_cnt, done_cnt, first_done;
  logic done_err;
  logic [15:0] cnt_at_done;

  always #5 clk = ~clk;

  aes_multiblock_fsm dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .mode_i(mode_i), .src_base_i(src_base_i),
    .dst_base_i(dst_base_i), .src_ready_i(src_ready_i), .snk_ready_i(snk_ready_i),
    .src_done_i(src_done_i), .snk_done_i(snk_done_i), .fifo_empty_i(fifo_empty_i),
    .blk_done_i(blk_done_i), .src_req_o(a_src_req), .snk_req_o(a_snk_req),
    .src_addr_o(a_src_addr), .snk_addr_o(a_snk_addr), .trans_size_o(a_trans_size),
    .line_length_o(a_line_length), .eng_clear_o(a_eng_clear), .eng_start_o(a_eng_start),
    .eng_enable_o(a_eng_enable), .eng_mode_o(a_eng_mode), .busy_o(a_busy),
    .done_o(a_done), .err_o(a_err), .blk_cnt_o(a_blk_cnt)
  );

  aes_multiblock_fsm #(.WDOG_W(4)) dut_wd (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .mode_i(mode_i), .src_base_i(src_base_i),
    .dst_base_i(dst_base_i), .src_ready_i(src_ready_i), .snk_ready_i(snk_ready_i),
    .src_done_i(src_done_i), .snk_done_i(snk_done_i), .fifo_empty_i(fifo_empty_i),
    .blk_done_i(blk_done_i), .src_req_o(b_src_req), .snk_req_o(b_snk_req),
    .src_addr_o(b_src_addr), .snk_addr_o(b_snk_addr), .trans_size_o(b_trans_size),
    .line_length_o(b_line_length), .eng_clear_o(b_eng_clear), .eng_start_o(b_eng_start),
    .eng_enable_o(b_eng_enable), .eng_mode_o(b_eng_mode), .busy_o(b_busy),
    .done_o(b_done), .err_o(b_err), .blk_cnt_o(b_blk_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; start_i = 1'b0; mode_i = 1'b0; n_blocks_i = '0;
    src_base_i = '0; dst_base_i = '0; src_ready_i = 1'b0; snk_ready_i = 1'b0;
    src_done_i = 1'b0; snk_done_i = 1'b0; fifo_empty_i = 1'b1; blk_done_i = 1'b0;
    tick();
    tick();
    check("rst_busy", a_busy, 0);
    check("rst_eng_clear", a_eng_clear, 1);
    check("rst_eng_enable", a_eng_enable, 1);
    check("rst_err", a_err, 0);
    check("rst_done", a_done, 0);
    check("rst_req", {a_src_req, a_snk_req, a_eng_start}, 0);
    check("rst_trans_size", a_trans_size, 0);
    check("rst_blk_cnt", a_blk_cnt, 0);
    reset_n = 1'b1;
    tick();

    // Basic 3-block encrypt job
    n_blocks_i = 16'd3; mode_i = 1'b0; src_base_i = 32'h1000; dst_base_i = 32'h2000;
    src_ready_i = 1'b1; snk_ready_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t1_wait_busy", a_busy, 1);
    check("t1_no_early_req", a_src_req, 0);
    tick();
    check("t1_reqs", {a_src_req, a_snk_req, a_eng_start}, 3'b111);
    check("t1_trans_size", a_trans_size, 12);
    check("t1_line_length", a_line_length, 12);
    check("t1_src_addr", a_src_addr, 32'h1000);
    check("t1_snk_addr", a_snk_addr, 32'h2000);
    check("t1_mode", a_eng_mode, 0);
    check("t1_eng_clear", a_eng_clear, 0);
    req_cnt = 0; done_cnt = 0; done_err = 1'b1; cnt_at_done = '0;
    for (int i = 0; i < 40; i++) begin
      blk_done_i = (i == 9) || (i == 19) || (i == 29);
      src_done_i = (i == 30);
      snk_done_i = (i == 31);
      tick();
      req_cnt += int'(a_src_req) + int'(a_snk_req);
      if (a_done) begin
        done_cnt++;
        done_err = a_err;
        cnt_at_done = a_blk_cnt;
      end
    end
    blk_done_i = 1'b0; src_done_i = 1'b0; snk_done_i = 1'b0;
    check("t1_single_req", req_cnt, 0);
    check("t1_done_pulses", done_cnt, 1);
    check("t1_err", done_err, 0);
    check("t1_blk_cnt", cnt_at_done, 3);
    check("t1_idle", a_busy, 0);

    // Sink not ready for 20 cycles
    n_blocks_i = 16'd2; src_ready_i = 1'b1; snk_ready_i = 1'b0; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      req_cnt += int'(a_src_req) + int'(a_snk_req) + int'(a_eng_start);
    end
    check("t2_no_req", req_cnt, 0);
    check("t2_still_busy", a_busy, 1);
    snk_ready_i = 1'b1;
    tick();
    check("t2_req_after_ready", {a_src_req, a_snk_req}, 2'b11);
    tick();
    blk_done_i = 1'b1;
    tick();
    tick();
    blk_done_i = 1'b0; src_done_i = 1'b1; snk_done_i = 1'b1;
    tick();
    src_done_i = 1'b0; snk_done_i = 1'b0;
    check("t2_done", a_done, 1);
    check("t2_blk_cnt", a_blk_cnt, 2);
    check("t2_enable_low", a_eng_enable, 0);
    tick();
    check("t2_idle", a_busy, 0);

    // Zero-length job
    n_blocks_i = 16'd0; start_i = 1'b1;
    req_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      start_i = 1'b0;
      req_cnt += int'(a_src_req) + int'(a_snk_req);
      if (a_done) done_cnt++;
    end
    check("t3_no_req", req_cnt, 0);
    check("t3_done_pulses", done_cnt, 1);
    check("t3_blk_cnt", a_blk_cnt, 0);
    check("t3_idle", a_busy, 0);

    // Watchdog timeout on the WDOG_W=4 instance
    do_clear();
    n_blocks_i = 16'd1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("t4_starting", b_src_req, 1);
    first_done = 0;
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (b_done && first_done == 0) begin
        first_done = j;
        check("t4_err_at_error", b_err, 1);
      end
    end
    check("t4_timeout_cycle", first_done, 16);
    check("t4_err_sticky", b_err, 1);
    check("t4_idle", b_busy, 0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("t4_start_clears_err", b_err, 0);

    // Early src done, extra blk_done pulses, saturation at 4
    do_clear();
    n_blocks_i = 16'd4; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    blk_done_i = 1'b1;
    tick();
    src_done_i = 1'b1;
    tick();
    src_done_i = 1'b0; snk_done_i = 1'b1;
    tick();
    blk_done_i = 1'b0; snk_done_i = 1'b0;
    tick();
    check("t5_not_done_at_3", a_done, 0);
    check("t5_cnt_3", a_blk_cnt, 3);
    blk_done_i = 1'b1; fifo_empty_i = 1'b0;
    tick();
    tick();
    tick();
    check("t5_not_done_fifo", a_done, 0);
    check("t5_cnt_sat", a_blk_cnt, 4);
    blk_done_i = 1'b0; fifo_empty_i = 1'b1;
    tick();
    check("t5_done", a_done, 1);
    check("t5_cnt_final", a_blk_cnt, 4);
    tick();

    // Clear mid-job in decrypt mode, then a normal decrypt job
    do_clear();
    n_blocks_i = 16'd2; mode_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("t6_mode_latched", a_eng_mode, 1);
    tick();
    blk_done_i = 1'b1;
    tick();
    blk_done_i = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_clear_idle", a_busy, 0);
    check("t6_clear_eng_clear", a_eng_clear, 1);
    check("t6_clear_no_done", a_done, 0);
    check("t6_clear_blk_cnt", a_blk_cnt, 0);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (a_done) done_cnt++;
    end
    check("t6_no_done_after_clear", done_cnt, 0);
    n_blocks_i = 16'd1; mode_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("t6_restart_req", a_src_req, 1);
    check("t6_restart_mode", a_eng_mode, 1);
    tick();
    blk_done_i = 1'b1; src_done_i = 1'b1; snk_done_i = 1'b1;
    tick();
    blk_done_i = 1'b0; src_done_i = 1'b0; snk_done_i = 1'b0;
    check("t6_restart_done", a_done, 1);
    check("t6_restart_err", a_err, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
